// File: rtl/bench_race_harness.sv
// bench_race_harness: launches NUM_CH channel engines together, times each done, flags
// timeouts and picks the fastest. Define BENCH_REPEAT_EN for averaged multi-pass runs.
module bench_race_harness #(
  parameter int NUM_CH        = 4,
  parameter int CNT_W         = 32,
  parameter int AUTOSTART_CYC = 256,
  parameter int DEBOUNCE_CYC  = 16,
  parameter int TIMEOUT_CYC   = 1048576,
  parameter int LOG2_RUNS     = 3,
  localparam int IDX_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    sysclk,
  input  logic                    rst,
  input  logic                    trig_in,
  output logic [NUM_CH-1:0]       ch_start,
  input  logic [NUM_CH-1:0]       ch_done,
  output logic [NUM_CH*CNT_W-1:0] t_flat,
  output logic [NUM_CH-1:0]       ch_timeout,
  output logic [IDX_W-1:0]        winner_idx,
  output logic [NUM_CH-1:0]       winner_onehot,
  output logic                    busy,
  output logic                    done
);

`ifdef BENCH_REPEAT_EN
  localparam int L2R = LOG2_RUNS;
`else
  // Single pass: the accumulate/average path degenerates to a plain time latch.
  localparam int L2R = 0 * LOG2_RUNS;
`endif
  localparam int PASSES = 1 << L2R;
  localparam int PASS_W = (L2R > 0) ? L2R : 1;
  localparam int ACC_W  = CNT_W + L2R;
  localparam int DB_W   = $clog2(DEBOUNCE_CYC + 1);
  localparam int AS_W   = $clog2(AUTOSTART_CYC + 1);
  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT_CYC);

  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_RUN, S_GAP, S_DECIDE, S_DONE} state_t;

  function automatic logic [CNT_W-1:0] avg_sat(input logic [ACC_W-1:0] sum);
    logic [ACC_W-1:0] q;
    q = sum >> L2R;
    if (q > ACC_W'({CNT_W{1'b1}})) return '1;
    return q[CNT_W-1:0];
  endfunction

  logic            trig_p0, trig_p1, trig_p2, deb_level, armed, trig_pulse, stable;
  logic [DB_W-1:0] deb_cnt;
  logic [AS_W-1:0] auto_cnt;
  logic            auto_pulse, start;

  assign stable     = (deb_cnt == DB_W'(DEBOUNCE_CYC));
  assign auto_pulse = (auto_cnt == AS_W'(AUTOSTART_CYC - 1));
  assign start      = auto_pulse | trig_pulse;

  // Trigger sync/debounce; armed blocks a trigger that was already high out of reset
  always_ff @(posedge sysclk) begin
    if (rst) begin
      trig_p0 <= 1'b0; trig_p1 <= 1'b0; trig_p2 <= 1'b0;
      deb_cnt <= '0; deb_level <= 1'b0; armed <= 1'b0; trig_pulse <= 1'b0;
      auto_cnt <= '0;
    end else begin
      trig_p0 <= trig_in;
      trig_p1 <= trig_p0;
      trig_p2 <= trig_p1;
      if (trig_p1 != trig_p2) deb_cnt <= '0;
      else if (!stable)       deb_cnt <= deb_cnt + DB_W'(1);
      trig_pulse <= stable && trig_p2 && !deb_level && armed;
      if (stable) begin
        deb_level <= trig_p2;
        if (!trig_p2) armed <= 1'b1;
      end
      if (auto_cnt != AS_W'(AUTOSTART_CYC)) auto_cnt <= auto_cnt + AS_W'(1);
    end
  end

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [NUM_CH-1:0] fin, hit;
  logic              all_fin;
  logic [ACC_W-1:0]  acc   [NUM_CH];
  logic [CNT_W-1:0]  t_reg [NUM_CH];
  logic [PASS_W-1:0] pass_cnt;
  logic [IDX_W-1:0]  scan_idx, best_idx;
  logic [CNT_W-1:0]  best_val, scan_val;
  logic              best_found, scan_take;

  assign hit     = ch_done & ~fin;
  assign all_fin = &(fin | ch_done);

  always_comb begin
    scan_val  = avg_sat(acc[scan_idx]);
    scan_take = !ch_timeout[scan_idx] && (!best_found || scan_val < best_val);
  end

  always_ff @(posedge sysclk) begin
    if (rst) begin
      state <= S_IDLE; ch_start <= '0; ch_timeout <= '0; winner_idx <= '0;
      winner_onehot <= '0; busy <= 1'b0; done <= 1'b0;
      cnt <= '0; fin <= '0; pass_cnt <= '0;
      scan_idx <= '0; best_idx <= '0; best_val <= '0; best_found <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        acc[i]   <= '0;
        t_reg[i] <= '0;
      end
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state <= S_LAUNCH; ch_start <= '1; cnt <= CNT_W'(1); fin <= '0; pass_cnt <= '0;
            ch_timeout <= '0; winner_idx <= '0; winner_onehot <= '0;
            busy <= 1'b1; done <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
              acc[i]   <= '0;
              t_reg[i] <= '0;
            end
          end
        end
        S_GAP: begin
          state <= S_LAUNCH; ch_start <= '1; cnt <= CNT_W'(1); fin <= '0;
        end
        S_LAUNCH, S_RUN: begin
          // cnt already holds 1 in LAUNCH, so a done seen there is timed as 1
          ch_start <= '0;
          fin      <= fin | ch_done;
          for (int i = 0; i < NUM_CH; i++)
            if (hit[i]) acc[i] <= acc[i] + ACC_W'(cnt);
          if (state == S_LAUNCH) begin
            state <= S_RUN;
          end else begin
            cnt <= cnt + CNT_W'(1);
            if (all_fin || cnt == TMO) begin
              for (int i = 0; i < NUM_CH; i++)
                if (!(fin[i] || ch_done[i])) begin
                  ch_timeout[i] <= 1'b1;
                  acc[i]        <= acc[i] + ACC_W'(TMO);
                end
              if (pass_cnt == PASS_W'(PASSES - 1)) begin
                state <= S_DECIDE; scan_idx <= '0; best_found <= 1'b0;
                best_val <= '0; best_idx <= '0;
              end else begin
                state <= S_GAP; pass_cnt <= pass_cnt + PASS_W'(1);
              end
            end
          end
        end
        S_DECIDE: begin
          t_reg[scan_idx] <= ch_timeout[scan_idx] ? '1 : scan_val;
          if (scan_take) begin
            best_found <= 1'b1; best_val <= scan_val; best_idx <= scan_idx;
          end
          if (scan_idx == IDX_W'(NUM_CH - 1)) begin
            state <= S_DONE; busy <= 1'b0; done <= 1'b1;
            if (scan_take) begin
              winner_idx    <= scan_idx;
              winner_onehot <= NUM_CH'(1) << scan_idx;
            end else if (best_found) begin
              winner_idx    <= best_idx;
              winner_onehot <= NUM_CH'(1) << best_idx;
            end
          end else begin
            scan_idx <= scan_idx + IDX_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_t
    assign t_flat[g*CNT_W +: CNT_W] = t_reg[g];
  end

endmodule

// File: tb/tb_bench_race_harness.sv
// Bench for bench_race_harness: vector table applied through a done-time scoreboard,
// plus hand sequences for autostart timing, trigger bounce and mid-run reset.
`timescale 1ns/1ps
module tb_bench_race_harness;
  localparam int NUM_CH = 4, CNT_W = 32, AUTO = 20, DEB = 4, TMO = 100, L2R = 2;
`ifdef BENCH_REPEAT_EN
  localparam int PASSES = 1 << L2R;
`else
  localparam int PASSES = 1;
`endif
  localparam int NEVER = -1;

  logic clk = 1'b0, rst = 1'b1, trig_in = 1'b0;
  logic [3:0]   ch_start, ch_done, ch_timeout, winner_onehot;
  logic [127:0] t_flat;
  logic [1:0]   winner_idx;
  logic         busy, done;

  bench_race_harness #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .AUTOSTART_CYC(AUTO),
    .DEBOUNCE_CYC(DEB), .TIMEOUT_CYC(TMO), .LOG2_RUNS(L2R)) dut (
    .sysclk(clk), .rst(rst), .trig_in(trig_in), .ch_start(ch_start), .ch_done(ch_done),
    .t_flat(t_flat), .ch_timeout(ch_timeout), .winner_idx(winner_idx),
    .winner_onehot(winner_onehot), .busy(busy), .done(done));

  always #5 clk = ~clk;

  typedef struct {
    int          d[4];
    logic [31:0] t[4];
    logic [3:0]  tmo;
    logic [1:0]  widx;
    logic [3:0]  oh;
    int          lat;
  } vec_t;

  int   tests = 0, fails = 0;
  vec_t sb[$];
  int   dly[4] = '{NEVER, NEVER, NEVER, NEVER};
  int   step0 = 0, pass_ref = 0;
  int   since = 100000, starts = 0, done_rises = 0;
  logic done_q = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int d0, d1, d2, d3,
                              input logic [31:0] t0, t1, t2, t3,
                              input logic [3:0] tmo, input logic [1:0] widx,
                              input logic [3:0] oh, input int lat);
    vec_t v;
    v.d = '{d0, d1, d2, d3};
    v.t = '{t0, t1, t2, t3};
    v.tmo = tmo; v.widx = widx; v.oh = oh; v.lat = lat;
    return v;
  endfunction

  // Channel stubs (level done, d cycles after ch_start) and the done-side scoreboard
  always @(negedge clk) begin
    vec_t e;
    if (ch_start != 4'b0) begin
      since = 0;
      starts++;
    end else if (since < 100000) begin
      since++;
    end
    if (done && !done_q) begin
      done_rises++;
      if (sb.size() == 0) check("scoreboard_empty", 64'(sb.size()), 64'(1));
      else begin
        e = sb.pop_front();
        for (int i = 0; i < 4; i++)
          check($sformatf("t%0d", i), 64'(t_flat[i*32 +: 32]), 64'(e.t[i]));
        check("ch_timeout", 64'(ch_timeout), 64'(e.tmo));
        check("winner_idx", 64'(winner_idx), 64'(e.widx));
        check("winner_onehot", 64'(winner_onehot), 64'(e.oh));
        check("busy_at_done", 64'(busy), 64'(0));
        check("done_latency", 64'(since), 64'(e.lat));
      end
    end
    done_q = done;
    for (int i = 0; i < 4; i++) begin
      int d;
      d = dly[i];
      if (i == 0 && d != NEVER) d = d + step0 * (starts - pass_ref - 1);
      ch_done[i] = (d != NEVER) && (since >= d);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_dly(input vec_t v);
    for (int i = 0; i < 4; i++) dly[i] = v.d[i];
  endtask

  task automatic wait_done(input int r0, input int bound);
    int n;
    n = 0;
    while (done_rises == r0 && n < bound) begin
      tick();
      n++;
    end
    check("done_seen_once", 64'(done_rises - r0), 64'(1));
  endtask

  task automatic wait_launch(input int bound, output int n);
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (ch_start == 4'b0 && n < bound);
  endtask

  task automatic pulse_trig();
    trig_in = 1'b1;
    repeat (12) tick();
    trig_in = 1'b0;
    repeat (12) tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected summary");
    $fatal(1);
  end

  initial begin
    vec_t tab[6];
    vec_t v;
    int   n, s0, r0;

    tab[0] = mk(10, 20, 5, 40,  10, 20, 5, 40,  4'b0000, 2'd2, 4'b0100, 45);
    tab[1] = mk(7, 7, 9, 9,     7, 7, 9, 9,     4'b0000, 2'd0, 4'b0001, 14);
    tab[2] = mk(30, 50, 60, NEVER, 30, 50, 60, 32'hFFFF_FFFF, 4'b1000, 2'd0, 4'b0001, 105);
    tab[3] = mk(NEVER, NEVER, NEVER, NEVER, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                32'hFFFF_FFFF, 4'b1111, 2'd0, 4'b0000, 105);
    tab[4] = mk(33, 12, 12, 50, 33, 12, 12, 50, 4'b0000, 2'd1, 4'b0010, 55);
    tab[5] = mk(0, 3, 1, 2,     1, 3, 1, 2,     4'b0000, 2'd0, 4'b0001, 8);

    // Reset state, then the autostart run
    set_dly(tab[0]);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ctrl", 64'({ch_start, ch_timeout, winner_idx, winner_onehot, busy, done}), 64'(0));
    check("reset_t_flat", 64'(|t_flat), 64'(0));
    sb.push_back(tab[0]);
    r0 = done_rises;
    @(posedge clk);
    #1 rst = 1'b0;
    wait_launch(AUTO + 20, n);
    check("autostart_cycle", 64'(n), 64'(AUTO));
    check("launch_all_ones", 64'(ch_start), 64'(4'hF));
    @(negedge clk);
    check("launch_one_cycle", 64'(ch_start), 64'(0));
    wait_done(r0, 200 * PASSES);

    for (int k = 1; k < 6; k++) begin
      set_dly(tab[k]);
      sb.push_back(tab[k]);
      r0 = done_rises;
      pulse_trig();
      wait_done(r0, 200 * PASSES);
    end

    // Bouncing trigger, then stable; a second press during RUN must be dropped
    v = mk(35, 45, 25, 50, 35, 45, 25, 50, 4'b0000, 2'd2, 4'b0100, 55);
    set_dly(v);
    sb.push_back(v);
    s0 = starts;
    r0 = done_rises;
    for (int k = 0; k < 10; k++) begin
      trig_in = (k % 2 == 0);
      repeat (3) tick();
    end
    check("bounce_no_launch", 64'(starts - s0), 64'(0));
    trig_in = 1'b1;
    wait_launch(40, n);
    check("stable_launch", 64'(ch_start), 64'(4'hF));
    tick();
    trig_in = 1'b0;
    repeat (8) tick();
    trig_in = 1'b1;
    repeat (8) tick();
    trig_in = 1'b0;
    wait_done(r0, 250 * PASSES);
    repeat (80) tick();
    check("launches_per_start", 64'(starts - s0), 64'(PASSES));
    check("single_done_rise", 64'(done_rises - r0), 64'(1));

    // Reset mid-RUN aborts, then a fresh autostart
    v = mk(30, 40, 50, 60, 30, 40, 50, 60, 4'b0000, 2'd0, 4'b0001, 65);
    set_dly(v);
    trig_in = 1'b1;
    wait_launch(40, n);
    check("pre_reset_launch", 64'(ch_start), 64'(4'hF));
    tick();
    trig_in = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("midrun_reset_ctrl",
          64'({ch_start, ch_timeout, winner_idx, winner_onehot, busy, done}), 64'(0));
    check("midrun_reset_t_flat", 64'(|t_flat), 64'(0));
    sb.push_back(v);
    r0 = done_rises;
    wait_launch(AUTO + 20, n);
    check("re_autostart_cycle", 64'(n), 64'(AUTO));
    wait_done(r0, 250 * PASSES);

`ifdef BENCH_REPEAT_EN
    // ch0 pass times 10,12,14,16 average to 13
    v = mk(10, 20, 30, 40, 13, 20, 30, 40, 4'b0000, 2'd0, 4'b0001, 45);
    set_dly(v);
    step0 = 2;
    pass_ref = starts;
    s0 = starts;
    sb.push_back(v);
    r0 = done_rises;
    pulse_trig();
    wait_done(r0, 1000);
    check("repeat_launches", 64'(starts - s0), 64'(4));
    step0 = 0;
`endif

    check("scoreboard_drained", 64'(sb.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
